uart_rx_frame: RTL and testbench
================================

Name: uart_rx_frame

Overview:
UART receive framer clocked by the scaled oversampling clock from the receive baud generator. That clock runs at prescale × baud.
Detects the start bit, majority-votes three mid-bit samples per bit, and shifts in data LSB first. Optionally checks parity, then checks the stop bit.
Delivers each received word with a one-cycle valid pulse plus error flags to the downstream receive FIFO / register interface.

Parameters:
DATA_WIDTH, 8, number of data bits per frame (5..9).

Ports:
i_clk  input  1  oversampling clock from the baud generator output.
i_arst_n  input  1  asynchronous active-low reset.
i_rx_serial  input  1  raw serial line; idles high.
i_prescale  input  6  samples per bit: 8, 16 or 32; any other value is treated as 8.
i_par_en  input  1  1 = a parity bit follows the data bits.
i_par_type  input  1  0 = even parity, 1 = odd parity.
o_data  output  DATA_WIDTH  last good received word.
o_data_valid  output  1  one-cycle pulse; o_data updated.
o_par_err  output  1  one-cycle pulse; parity mismatch.
o_stop_err  output  1  one-cycle pulse; stop bit sampled 0.
o_busy  output  1  high while a frame is in progress.

Behaviour:
- Clock is i_clk; reset is i_arst_n, asynchronous, active-low.
- Reset values:
  - All outputs 0; state IDLE; all counters 0.
  - Two-flop synchronizer on i_rx_serial resets to 1.
  - Reset mid-frame aborts the frame with no pulses.
- All logic uses the synchronized line (rx_s), which lags the pin by 2 cycles.
- Configuration latch: i_prescale (decoded to P = 8/16/32), i_par_en and i_par_type are latched on leaving IDLE. Changes mid-frame are ignored.
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE → START when rx_s == 0. The first START cycle is cycle 0; edge_cnt = 0 there.
- edge_cnt (6 bits):
  - Increments every non-IDLE cycle.
  - At P-1 it wraps to 0 and the bit period advances.
- Sampling:
  - Samples are taken in the cycles where edge_cnt = P/2-1, P/2 and P/2+1.
  - The bit value is the majority of the 3 samples, decided in the P/2+1 cycle.
- START: if the majority is 1, treat as a glitch: go to IDLE the next cycle with no outputs. Otherwise continue to DATA at the wrap.
- DATA:
  - Shift the majority value in LSB first.
  - bit_cnt counts 0..DATA_WIDTH-1.
  - After the last bit, go to PARITY if the latched par_en is set, else STOP.
- PARITY:
  - expected = XOR of the data bits; inverted when par_type = 1.
  - The mismatch result is held until the STOP decision.
- STOP: decided in the cycle with edge_cnt = P/2+1. The next state is IDLE regardless of outcome; the rest of the stop bit is not waited out.
- Outputs, registered at the stop decision and visible the following cycle:
  - o_data_valid = stop_ok AND NOT par_mismatch. o_data is loaded only when valid.
  - o_par_err = par_mismatch.
  - o_stop_err = NOT stop_ok.
  - Both errors may pulse together. No pulse lasts more than one cycle.
- Latency: pulses are visible in cycle (1 + DATA_WIDTH + par_en)·P + P/2 + 2, counted from START cycle 0.
- Line held low (break): o_stop_err pulses, then START is re-entered immediately since rx_s is still 0.
- Back-to-back frames: a start edge in the cycle immediately after the STOP→IDLE transition must be accepted with no lost frame.
- o_busy = (state != IDLE).
- Cycle-accurate across reset: all counters use the latched P; no division by a run-time value.

Test Plan:
- P=16, no parity, frame 0xA5 (16 cycles per bit) → o_data_valid pulse in cycle 154 after START entry, o_data=0xA5, no errors.
- P=8, even parity, 0x3C with parity bit 0 → valid in cycle 86, o_data=0x3C. Repeat with parity bit 1 → o_par_err pulse, no valid, o_data keeps 0x3C.
- P=32, no parity, 0x81 with stop bit 0 → o_stop_err pulse only; the line then stays low → o_busy stays high (break).
- P=16, 3-cycle low glitch on idle line → returns to IDLE after START decision, no pulses, o_busy low by cycle 10.
- Two back-to-back frames 0x11, 0xEE at P=16 → two valid pulses with correct data. Then assert i_arst_n low mid-DATA of a third frame → outputs 0, o_busy 0, no pulse.
- i_prescale=20 with 0x5A, then change i_prescale mid-frame from 8 to 16 → both frames decode at P=8, o_data=0x5A.

Source files
------------

// File: rtl/uart_rx_frame.sv
// uart_rx_frame
// Receive framer that runs on the oversampling clock (prescale x baud).
// It finds the start bit and takes a majority vote of three samples around
// the middle of each bit. Data bits are assembled LSB first. An optional
// parity bit and then the stop bit are checked. The finished word goes out
// with a one-cycle valid pulse and error flags.
//
// Ports
//   i_clk          oversampling clock from the baud generator
//   i_arst_n       asynchronous active-low reset
//   i_rx_serial    raw serial line, idles high
//   i_prescale     samples per bit: 8, 16 or 32 (anything else = 8)
//   i_par_en       1 = parity bit follows the data bits
//   i_par_type     0 = even, 1 = odd parity
//   o_data         last good received word
//   o_data_valid   one-cycle pulse, o_data updated
//   o_par_err      one-cycle pulse, parity mismatch
//   o_stop_err     one-cycle pulse, stop bit sampled 0
//   o_busy         frame in progress
//
// state  | meaning
// IDLE   | waiting for rx_s low
// START  | start bit; a majority of 1 is treated as a glitch and aborts
// DATA   | DATA_WIDTH data bits, LSB first
// PARITY | parity bit, mismatch held until the stop decision
// STOP   | stop bit; the decision at mid-bit returns to IDLE at once

module uart_rx_frame #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  i_clk,
    input  logic                  i_arst_n,
    input  logic                  i_rx_serial,
    input  logic [5:0]            i_prescale,
    input  logic                  i_par_en,
    input  logic                  i_par_type,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_data_valid,
    output logic                  o_par_err,
    output logic                  o_stop_err,
    output logic                  o_busy
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } state_t;

    localparam logic [3:0] BIT_LAST = 4'(DATA_WIDTH - 1);

    state_t                r_state;
    logic                  r_rx_meta;
    logic                  r_rx_s;
    logic [5:0]            r_edge_cnt;
    logic [5:0]            r_p;
    logic [3:0]            r_bit_cnt;
    logic                  r_par_en;
    logic                  r_par_type;
    logic                  r_s0;
    logic                  r_s1;
    logic                  r_par_mis;
    logic [DATA_WIDTH-1:0] r_shift;

    logic [5:0] w_p_dec;
    logic [5:0] w_half;
    logic       w_samp_a;
    logic       w_samp_b;
    logic       w_mid;
    logic       w_wrap;
    logic       w_maj;
    logic       w_par_exp;
    logic       w_good;

    always_comb begin
        w_p_dec = 6'd8;
        case (i_prescale)
            6'd16:   w_p_dec = 6'd16;
            6'd32:   w_p_dec = 6'd32;
            default: w_p_dec = 6'd8;
        endcase
    end

    // Sample points come from the latched P only, so a prescale change on
    // the pins never disturbs a frame already in flight.
    assign w_half    = {1'b0, r_p[5:1]};
    assign w_samp_a  = (r_edge_cnt == (w_half - 6'd1));
    assign w_samp_b  = (r_edge_cnt == w_half);
    assign w_mid     = (r_edge_cnt == (w_half + 6'd1));
    assign w_wrap    = (r_edge_cnt == (r_p - 6'd1));
    // Third vote is the live synchronized sample taken in the decision cycle.
    assign w_maj     = (r_s0 & r_s1) | (r_s0 & r_rx_s) | (r_s1 & r_rx_s);
    assign w_par_exp = (^r_shift) ^ r_par_type;
    assign w_good    = w_maj & ~r_par_mis;

    assign o_busy = (r_state != ST_IDLE);

    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            r_state      <= ST_IDLE;
            r_rx_meta    <= 1'b1;
            r_rx_s       <= 1'b1;
            r_edge_cnt   <= '0;
            r_p          <= 6'd8;
            r_bit_cnt    <= '0;
            r_par_en     <= 1'b0;
            r_par_type   <= 1'b0;
            r_s0         <= 1'b0;
            r_s1         <= 1'b0;
            r_par_mis    <= 1'b0;
            r_shift      <= '0;
            o_data       <= '0;
            o_data_valid <= 1'b0;
            o_par_err    <= 1'b0;
            o_stop_err   <= 1'b0;
        end else begin
            o_data_valid <= 1'b0;
            o_par_err    <= 1'b0;
            o_stop_err   <= 1'b0;
            r_rx_meta    <= i_rx_serial;
            r_rx_s       <= r_rx_meta;

            if (r_state != ST_IDLE) begin
                r_edge_cnt <= w_wrap ? 6'd0 : r_edge_cnt + 6'd1;
                if (w_samp_a) r_s0 <= r_rx_s;
                if (w_samp_b) r_s1 <= r_rx_s;
            end

            case (r_state)
                ST_IDLE: begin
                    if (!r_rx_s) begin
                        r_state    <= ST_START;
                        r_edge_cnt <= 6'd0;
                        r_p        <= w_p_dec;
                        r_par_en   <= i_par_en;
                        r_par_type <= i_par_type;
                        r_bit_cnt  <= '0;
                        r_par_mis  <= 1'b0;
                    end
                end
                ST_START: begin
                    if (w_mid && w_maj) begin
                        r_state    <= ST_IDLE;
                        r_edge_cnt <= 6'd0;
                    end else if (w_wrap) begin
                        r_state <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (w_mid) r_shift <= {w_maj, r_shift[DATA_WIDTH-1:1]};
                    if (w_wrap) begin
                        if (r_bit_cnt == BIT_LAST)
                            r_state <= r_par_en ? ST_PARITY : ST_STOP;
                        else
                            r_bit_cnt <= r_bit_cnt + 4'd1;
                    end
                end
                ST_PARITY: begin
                    if (w_mid) r_par_mis <= (w_maj != w_par_exp);
                    if (w_wrap) r_state <= ST_STOP;
                end
                ST_STOP: begin
                    // Leave at mid-bit so a start edge right behind the stop
                    // bit is never missed.
                    if (w_mid) begin
                        r_state      <= ST_IDLE;
                        r_edge_cnt   <= 6'd0;
                        o_data_valid <= w_good;
                        o_par_err    <= r_par_mis;
                        o_stop_err   <= ~w_maj;
                        if (w_good) o_data <= r_shift;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_frame.sv
module tb_uart_rx_frame;

    localparam int MAXN = 20000;

    logic       clk = 1'b0;
    logic       arst_n;
    logic       rx;
    logic [5:0] prescale;
    logic       par_en;
    logic       par_type;
    logic [7:0] data;
    logic       data_valid;
    logic       par_err;
    logic       stop_err;
    logic       busy;

    uart_rx_frame #(.DATA_WIDTH(8)) dut (
        .i_clk        (clk),
        .i_arst_n     (arst_n),
        .i_rx_serial  (rx),
        .i_prescale   (prescale),
        .i_par_en     (par_en),
        .i_par_type   (par_type),
        .o_data       (data),
        .o_data_valid (data_valid),
        .o_par_err    (par_err),
        .o_stop_err   (stop_err),
        .o_busy       (busy)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int n = 0;
    bit rec_on = 1'b0;

    // Inputs seen at posedge k, outputs seen in cycle k (after posedge k).
    logic       pin_rec   [MAXN];
    logic [5:0] cfgp_rec  [MAXN];
    bit         cfgpe_rec [MAXN];
    bit         cfgpt_rec [MAXN];
    bit         ov_rec    [MAXN];
    bit         ope_rec   [MAXN];
    bit         ose_rec   [MAXN];
    bit         ob_rec    [MAXN];
    logic [7:0] od_rec    [MAXN];

    bit         e_v   [MAXN];
    bit         e_pe  [MAXN];
    bit         e_se  [MAXN];
    bit         e_b   [MAXN];
    logic [7:0] e_new [MAXN];

    always @(posedge clk) begin
        if (rec_on && n < MAXN) begin
            pin_rec[n]   = rx;
            cfgp_rec[n]  = prescale;
            cfgpe_rec[n] = par_en;
            cfgpt_rec[n] = par_type;
        end
    end

    task automatic tick(input logic v);
        @(negedge clk);
        if (n < MAXN) begin
            ov_rec[n]  = data_valid;
            ope_rec[n] = par_err;
            ose_rec[n] = stop_err;
            ob_rec[n]  = busy;
            od_rec[n]  = data;
        end
        n++;
        rx = v;
    endtask

    task automatic chk(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h)", name, got, got, want, want);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rec_on = 1'b0;
        arst_n = 1'b0;
        rx     = 1'b1;
        #1;
        chk("rst_data", int'(data), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_pulses", int'(data_valid) + int'(par_err) + int'(stop_err), 0);
        repeat (2) @(negedge clk);
        arst_n = 1'b1;
        n      = 0;
        rec_on = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] d, input int pb, input bit with_par,
                              input logic par_bit, input logic stop_bit,
                              input int chg_p, output int fall);
        fall = n + 1;
        repeat (pb) tick(1'b0);
        if (chg_p != 0) prescale = 6'(chg_p);
        for (int i = 0; i < 8; i++) repeat (pb) tick(d[i]);
        if (with_par) repeat (pb) tick(par_bit);
        repeat (pb) tick(stop_bit);
    endtask

    function automatic int pdec(input logic [5:0] p);
        if (p == 6'd16) return 16;
        if (p == 6'd32) return 32;
        return 8;
    endfunction

    // Synchronized line as seen by the framer in cycle k.
    function automatic logic s_at(input int k, input int nn);
        if (k >= 1 && (k - 1) < nn) return pin_rec[k-1];
        return 1'b1;
    endfunction

    function automatic logic maj_at(input int t, input int k, input int p, input int nn);
        int base;
        int ones;
        base = t + k * p + p / 2;
        ones = int'(s_at(base - 1, nn)) + int'(s_at(base, nn)) + int'(s_at(base + 1, nn));
        return (ones >= 2);
    endfunction

    function automatic int first_pulse(input int kind, input int from);
        for (int c = from; c < n && c < MAXN; c++) begin
            if (kind == 0 && ov_rec[c]) return c;
            if (kind == 1 && ope_rec[c]) return c;
            if (kind == 2 && ose_rec[c]) return c;
        end
        return -1;
    endfunction

    function automatic int count_pulse(input int kind, input int from);
        int cnt;
        cnt = 0;
        for (int c = from; c < n && c < MAXN; c++) begin
            if (kind == 0 && ov_rec[c]) cnt++;
            if (kind == 1 && ope_rec[c]) cnt++;
            if (kind == 2 && ose_rec[c]) cnt++;
        end
        return cnt;
    endfunction

    // Frame-level reference: walk the recorded line, find each start, vote
    // every bit at its mid-point and place the result pulse after the stop
    // mid-point. Then compare every recorded output cycle.
    task automatic check_segment(input string tag);
        int nn;
        int c;
        int t;
        int p;
        int ks;
        int dcy;
        bit pe;
        bit pt;
        bit mis;
        bit stop_ok;
        logic [7:0] d;
        logic [7:0] cur;
        nn = (n > MAXN) ? MAXN : n;
        for (int k = 0; k < nn; k++) begin
            e_v[k] = 0; e_pe[k] = 0; e_se[k] = 0; e_b[k] = 0; e_new[k] = '0;
        end
        c = 0;
        while (c < nn) begin
            if (s_at(c, nn)) begin
                c++;
            end else begin
                t = c + 1;
                if (t >= nn) break;
                p  = pdec(cfgp_rec[t]);
                pe = cfgpe_rec[t];
                pt = cfgpt_rec[t];
                if (maj_at(t, 0, p, nn)) begin
                    dcy = t + p / 2 + 1;
                    for (int k = t; k <= dcy && k < nn; k++) e_b[k] = 1;
                end else begin
                    for (int i = 0; i < 8; i++) d[i] = maj_at(t, 1 + i, p, nn);
                    mis = 0;
                    if (pe) mis = (maj_at(t, 9, p, nn) != ((^d) ^ pt));
                    ks = pe ? 10 : 9;
                    stop_ok = maj_at(t, ks, p, nn);
                    dcy = t + ks * p + p / 2 + 1;
                    for (int k = t; k <= dcy && k < nn; k++) e_b[k] = 1;
                    if (dcy + 1 < nn) begin
                        e_v[dcy+1]  = stop_ok && !mis;
                        e_pe[dcy+1] = mis;
                        e_se[dcy+1] = !stop_ok;
                        e_new[dcy+1] = d;
                    end
                end
                c = dcy + 1;
            end
        end
        cur = '0;
        for (int k = 0; k < nn; k++) begin
            if (e_v[k]) cur = e_new[k];
            checks++;
            if (ov_rec[k] != e_v[k] || ope_rec[k] != e_pe[k] || ose_rec[k] != e_se[k] ||
                ob_rec[k] != e_b[k] || od_rec[k] !== cur) begin
                errors++;
                $display("FAIL %s cycle %0d: got v=%0b pe=%0b se=%0b busy=%0b data=%02h want v=%0b pe=%0b se=%0b busy=%0b data=%02h",
                         tag, k, ov_rec[k], ope_rec[k], ose_rec[k], ob_rec[k], od_rec[k],
                         e_v[k], e_pe[k], e_se[k], e_b[k], cur);
            end
        end
    endtask

    initial begin
        int fa;
        int fb;
        int t;
        int pc;
        int p;
        int gl;
        logic [7:0] d;
        logic [5:0] plist [5];
        logic pbit;
        logic sbit;
        bit pe;
        bit pt;

        arst_n   = 1'b0;
        rx       = 1'b1;
        prescale = 6'd16;
        par_en   = 1'b0;
        par_type = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("init_busy", int'(busy), 0);
        chk("init_valid", int'(data_valid), 0);
        chk("init_data", int'(data), 0);
        @(negedge clk);
        arst_n = 1'b1;
        n      = 0;
        rec_on = 1'b1;

        // A: P=16, no parity, 0xA5
        repeat (5) tick(1'b1);
        send_frame(8'hA5, 16, 0, 1'b0, 1'b1, 0, fa);
        repeat (20) tick(1'b1);
        chk("A_rst_state", int'(ov_rec[0]) + int'(ob_rec[0]) + int'(od_rec[0]), 0);
        pc = first_pulse(0, 0);
        chk("A_latency", pc - (fa + 2), 154);
        if (pc >= 0) chk("A_data", int'(od_rec[pc]), 8'hA5);
        chk("A_errs", count_pulse(1, 0) + count_pulse(2, 0), 0);
        check_segment("A");

        // B: P=8, even parity, 0x3C good then bad parity
        do_reset();
        prescale = 6'd8; par_en = 1'b1; par_type = 1'b0;
        repeat (4) tick(1'b1);
        send_frame(8'h3C, 8, 1, 1'b0, 1'b1, 0, fa);
        repeat (6) tick(1'b1);
        send_frame(8'h3C, 8, 1, 1'b1, 1'b1, 0, fb);
        repeat (10) tick(1'b1);
        pc = first_pulse(0, 0);
        chk("B_latency", pc - (fa + 2), 86);
        if (pc >= 0) chk("B_data", int'(od_rec[pc]), 8'h3C);
        chk("B_perr_latency", first_pulse(1, 0) - (fb + 2), 86);
        chk("B_no_valid_bad", count_pulse(0, fb), 0);
        chk("B_data_kept", int'(od_rec[n-1]), 8'h3C);
        check_segment("B");

        // C: P=32, stop bit 0, then break
        do_reset();
        prescale = 6'd32; par_en = 1'b0;
        repeat (4) tick(1'b1);
        send_frame(8'h81, 32, 0, 1'b0, 1'b0, 0, fa);
        repeat (400) tick(1'b0);
        chk("C_serr_latency", first_pulse(2, 0) - (fa + 2), 306);
        chk("C_no_valid", count_pulse(0, 0), 0);
        chk("C_no_perr", count_pulse(1, 0), 0);
        chk("C_break_busy", int'(ob_rec[fa + 318]), 1);
        repeat (400) tick(1'b1);
        check_segment("C");

        // D: P=16, 3-cycle glitch
        do_reset();
        prescale = 6'd16;
        repeat (4) tick(1'b1);
        fa = n + 1;
        repeat (3) tick(1'b0);
        repeat (30) tick(1'b1);
        t = fa + 2;
        chk("D_busy_start", int'(ob_rec[t]), 1);
        chk("D_busy_decide", int'(ob_rec[t + 9]), 1);
        chk("D_idle_by_10", int'(ob_rec[t + 10]), 0);
        chk("D_no_pulses", count_pulse(0, 0) + count_pulse(1, 0) + count_pulse(2, 0), 0);
        check_segment("D");

        // E: back-to-back 0x11, 0xEE, then reset mid-DATA
        do_reset();
        repeat (3) tick(1'b1);
        send_frame(8'h11, 16, 0, 1'b0, 1'b1, 0, fa);
        send_frame(8'hEE, 16, 0, 1'b0, 1'b1, 0, fb);
        repeat (5) tick(1'b1);
        d = 8'h77;
        repeat (16) tick(1'b0);
        for (int i = 0; i < 4; i++) repeat (16) tick(d[i]);
        pc = first_pulse(0, 0);
        chk("E_first_latency", pc - (fa + 2), 154);
        if (pc >= 0) chk("E_first_data", int'(od_rec[pc]), 8'h11);
        pc = first_pulse(0, fa + 157);
        chk("E_second_latency", pc - (fb + 2), 154);
        if (pc >= 0) chk("E_second_data", int'(od_rec[pc]), 8'hEE);
        chk("E_busy_mid", int'(ob_rec[n-1]), 1);
        check_segment("E");
        do_reset();
        repeat (60) tick(1'b1);
        chk("E_after_rst_valid", count_pulse(0, 0), 0);
        chk("E_after_rst_busy", int'(ob_rec[n-1]), 0);
        check_segment("E2");

        // F: illegal prescale = 8, and mid-frame prescale change ignored
        do_reset();
        prescale = 6'd20;
        repeat (3) tick(1'b1);
        send_frame(8'h5A, 8, 0, 1'b0, 1'b1, 0, fa);
        repeat (4) tick(1'b1);
        prescale = 6'd8;
        send_frame(8'h5A, 8, 0, 1'b0, 1'b1, 16, fb);
        repeat (10) tick(1'b1);
        pc = first_pulse(0, 0);
        chk("F_p20_latency", pc - (fa + 2), 78);
        if (pc >= 0) chk("F_p20_data", int'(od_rec[pc]), 8'h5A);
        chk("F_chg_latency", first_pulse(0, fb) - (fb + 2), 78);
        chk("F_valid_count", count_pulse(0, 0), 2);
        chk("F_data_final", int'(od_rec[n-1]), 8'h5A);
        check_segment("F");

        // G: randomized frames, configs, errors and glitches
        do_reset();
        plist[0] = 6'd8; plist[1] = 6'd16; plist[2] = 6'd32; plist[3] = 6'd20; plist[4] = 6'd0;
        repeat (3) tick(1'b1);
        for (int f = 0; f < 40; f++) begin
            prescale = plist[$urandom_range(0, 4)];
            pe = 1'($urandom_range(0, 1));
            pt = 1'($urandom_range(0, 1));
            par_en = pe; par_type = pt;
            p = pdec(prescale);
            d = 8'($urandom_range(0, 255));
            pbit = (^d) ^ pt ^ ($urandom_range(0, 4) == 0);
            sbit = ($urandom_range(0, 5) != 0);
            send_frame(d, p, pe, pbit, sbit, 0, fa);
            repeat ($urandom_range(0, 4)) tick(1'b1);
            if ($urandom_range(0, 4) == 0) begin
                gl = $urandom_range(1, 3);
                repeat (gl) tick(1'b0);
                repeat (2 * p) tick(1'b1);
            end
        end
        repeat (80) tick(1'b1);
        check_segment("G");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
